// File: rtl/fetch_pkg.sv
// Shared widths, opcode constants and FSM state encoding for the fetch sequencer.
package fetch_pkg;
    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 8;
    localparam int OP_SIZE   = 8;
    localparam logic [OP_SIZE-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FET  = 2'd1,
        S_DEC  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    function automatic logic [OP_SIZE-1:0] opcode_of(input logic [WORD_SIZE-1:0] word);
        return word[WORD_SIZE-1 -: OP_SIZE];
    endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, decode and status signals of the fetch sequencer; master = sequencer side.
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic                 mem_req;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [WORD_SIZE-1:0] ir;
    logic                 ir_valid;
    logic                 ir_ready;
    logic                 branch_taken;
    logic [ADDR_SIZE-1:0] branch_target;
    logic                 halt_req;
    logic [ADDR_SIZE-1:0] pc;
    logic                 halted;
    logic                 fetch_err;

    modport master (
        output mem_req, mem_addr, ir, ir_valid, pc, halted, fetch_err,
        input  mem_ack, mem_rdata, ir_ready, branch_taken, branch_target, halt_req
    );

    modport slave (
        input  mem_req, mem_addr, ir, ir_valid, pc, halted, fetch_err,
        output mem_ack, mem_rdata, ir_ready, branch_taken, branch_target, halt_req
    );
endinterface

// File: rtl/pc_register.sv
// Program counter: load has priority over increment; increment wraps modulo 2^ADDR_SIZE.
module pc_register #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [ADDR_SIZE-1:0] i_load_val,
    input  logic                 i_inc,
    output logic [ADDR_SIZE-1:0] o_pc
);
    logic [ADDR_SIZE-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= '0;
        else if (i_load)
            r_pc <= i_load_val;
        else if (i_inc)
            r_pc <= r_pc + ADDR_SIZE'(1);
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch FSM: req/ack fetch into ir, valid/ready hand-off to decode,
// branch redirect, fetch timeout and terminal halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    fetch_sequencer_if.master bus
);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_ir;
    logic [7:0]           r_wait_cnt;
    logic                 r_fetch_err;
    logic                 r_mem_req;
    logic                 r_ir_valid;
    logic                 r_halted;

    logic                 w_accept;
    logic                 w_is_halt_op;
    logic                 w_load_pc;
    logic                 w_inc_pc;
    logic [ADDR_SIZE-1:0] w_pc;

    assign w_accept     = (r_state == S_DEC) && bus.ir_ready;
    assign w_is_halt_op = (opcode_of(r_ir) == HALT_OPCODE);
    // A halt opcode suppresses the branch; an external halt request does not.
    assign w_load_pc    = w_accept && !w_is_halt_op && bus.branch_taken;
    assign w_inc_pc     = (r_state == S_FET) && bus.mem_ack;

    pc_register #(.ADDR_SIZE(ADDR_SIZE)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load_pc),
        .i_load_val (bus.branch_target),
        .i_inc      (w_inc_pc),
        .o_pc       (w_pc)
    );

    // Moore flags are registered alongside the state so they always match it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
            r_mem_req   <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.halt_req) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state   <= S_FET;
                        r_mem_req <= 1'b1;
                    end
                end
                S_FET: begin
                    if (bus.mem_ack) begin
                        r_ir       <= bus.mem_rdata;
                        r_wait_cnt <= '0;
                        r_state    <= S_DEC;
                        r_mem_req  <= 1'b0;
                        r_ir_valid <= 1'b1;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= S_HALT;
                        r_mem_req   <= 1'b0;
                        r_halted    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DEC: begin
                    if (bus.ir_ready) begin
                        r_ir_valid <= 1'b0;
                        if (w_is_halt_op || bus.halt_req) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state   <= S_FET;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: r_state <= S_HALT;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = w_pc;
    assign bus.pc        = w_pc;
    assign bus.ir        = r_ir;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.halted    = r_halted;
    assign bus.fetch_err = r_fetch_err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// against a handshake-level reference model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_pc;
    logic [15:0] exp_ir;
    logic        exp_valid, exp_halt, exp_err, exp_idle;
    int          exp_wait;

    function automatic logic [15:0] rd(input logic [7:0] a);
        return 16'h0100 + {8'h00, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_all();
        chk("pc", {24'h0, bus.pc}, {24'h0, exp_pc});
        chk("ir", {16'h0, bus.ir}, {16'h0, exp_ir});
        chk("ir_valid", {31'h0, bus.ir_valid}, {31'h0, exp_valid});
        chk("halted", {31'h0, bus.halted}, {31'h0, exp_halt});
        chk("fetch_err", {31'h0, bus.fetch_err}, {31'h0, exp_err});
        chk("mem_req", {31'h0, bus.mem_req}, {31'h0, (!exp_valid && !exp_halt && !exp_idle)});
        if (bus.mem_req)
            chk("mem_addr", {24'h0, bus.mem_addr}, {24'h0, exp_pc});
    endtask

    // Drive one cycle of inputs, predict its effect, then check after the edge.
    task automatic cycle(input logic ack, input logic [15:0] rdata, input logic rdy,
                         input logic br, input logic [7:0] tgt, input logic hreq);
        bus.mem_ack       = ack;
        bus.mem_rdata     = rdata;
        bus.ir_ready      = rdy;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.halt_req      = hreq;
        if (exp_idle) begin
            exp_idle = 1'b0;
            if (hreq) exp_halt = 1'b1;
        end else if (!exp_halt && !exp_valid) begin
            if (ack) begin
                exp_ir    = rdata;
                exp_pc    = exp_pc + 8'd1;
                exp_valid = 1'b1;
                exp_wait  = 0;
            end else if (exp_wait == TIMEOUT - 1) begin
                exp_err  = 1'b1;
                exp_halt = 1'b1;
            end else begin
                exp_wait++;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
            if (exp_ir[15:8] == 8'hFF) begin
                exp_halt = 1'b1;
            end else begin
                if (br) exp_pc = tgt;
                if (hreq) exp_halt = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_mem_req", {31'h0, bus.mem_req}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 8'h00; exp_ir = 16'h0000; exp_valid = 1'b0; exp_halt = 1'b0;
        exp_err = 1'b0; exp_idle = 1'b1; exp_wait = 0;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  n;
        logic taken;
        logic saw_ff;
        logic wrapped;
        logic        r_ack, r_rdy, r_br, r_hreq;
        logic [15:0] r_data;

        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ir_ready = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = '0; bus.halt_req = 1'b0;
        @(negedge clk);
        do_reset();

        // T1: reset while a fetch is outstanding
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        chk("t1_first_addr", {24'h0, bus.mem_addr}, 32'h0);

        // T2: zero-wait stream with pc wrap
        do_reset();
        cnt = 0; saw_ff = 1'b0; wrapped = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, rd(bus.mem_addr), 1'b1, 1'b0, 8'h0, 1'b0);
            if (bus.ir_valid) cnt++;
            if (bus.pc == 8'hFF) saw_ff = 1'b1;
            if (saw_ff && bus.pc == 8'h00) wrapped = 1'b1;
        end
        chk("t2_valid_cnt", cnt, 300);
        chk("t2_pc_wrap", {31'h0, wrapped}, 32'h1);

        // T3: memory wait states and decode backpressure
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'hDEAD, 1'b0, 1'b1, 8'h99, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0, 8'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'hBEEF, 1'b0, 1'b1, 8'h66, 1'b0);
            chk("t3_no_req", {31'h0, bus.mem_req}, 32'h0);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 8'h0, 1'b0);
        chk("t3_next_addr", {24'h0, bus.mem_addr}, 32'h1);

        // T4: branch redirect at pc=0x10
        do_reset();
        taken = 1'b0;
        for (int i = 0; i < 100 && !taken; i++) begin
            if (bus.ir_valid && bus.pc == 8'h10) begin
                cycle(1'b1, rd(bus.mem_addr), 1'b1, 1'b1, 8'h40, 1'b0);
                taken = 1'b1;
            end else if (bus.ir_valid) begin
                cycle(1'b1, rd(bus.mem_addr), 1'b1, 1'b0, 8'h77, 1'b0);
            end else begin
                cycle(1'b1, rd(bus.mem_addr), 1'b1, 1'b1, 8'h77, 1'b0);
            end
        end
        chk("t4_reached", {31'h0, taken}, 32'h1);
        chk("t4_redirect", {24'h0, bus.mem_addr}, 32'h40);

        // T5: halt opcode, halt_req during fetch, halt_req in idle
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        cycle(1'b1, 16'hFF00, 1'b0, 1'b0, 8'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 8'h33, 1'b0);
        chk("t5_op_halted", {31'h0, bus.halted}, 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0202, 1'b1, 1'b1, 8'h44, 1'b1);
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1);
        cycle(1'b1, 16'h0A0A, 1'b0, 1'b0, 8'h0, 1'b1);
        chk("t5_fetch_done", {31'h0, bus.ir_valid}, 32'h1);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 8'h55, 1'b1);
        chk("t5_req_halted", {31'h0, bus.halted}, 32'h1);
        chk("t5_branch_pc", {24'h0, bus.pc}, 32'h55);
        do_reset();
        cycle(1'b1, 16'h0, 1'b1, 1'b0, 8'h0, 1'b1);
        chk("t5_idle_halt", {31'h0, bus.halted}, 32'h1);

        // T6: fetch timeout
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        n = 0;
        for (int i = 0; i < 3 * TIMEOUT && !bus.halted; i++) begin
            if (bus.mem_req) n++;
            cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        end
        chk("t6_req_cycles", n, TIMEOUT);
        chk("t6_fetch_err", {31'h0, bus.fetch_err}, 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0303, 1'b1, 1'b0, 8'h0, 1'b0);
        do_reset();
        chk("t6_err_cleared", {31'h0, bus.fetch_err}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (exp_halt) do_reset();
            if (exp_valid || exp_halt || exp_idle)
                r_ack = 1'($urandom_range(0, 1));
            else
                r_ack = (exp_wait >= 4) ? 1'b1 : ($urandom_range(0, 2) == 0);
            r_data = ($urandom_range(0, 29) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                                  : rd(bus.mem_addr);
            r_rdy  = 1'($urandom_range(0, 1));
            r_br   = ($urandom_range(0, 2) == 0);
            r_hreq = ($urandom_range(0, 39) == 0);
            cycle(r_ack, r_data, r_rdy, r_br, 8'($urandom_range(0, 255)), r_hreq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
